// File: rtl/peak_scan_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : peak_scan_unit
// Purpose  : Walks a programmable-length window of signed samples through a
//            req/ack read port. In peak mode it counts local peaks and tracks
//            the maximum. In valley mode it counts local valleys and tracks
//            the minimum.
// Ports    : clk_i / rst_ni          - clock, async active-low reset
//            start_i, mode_i         - scan request (level), 0=peak 1=valley
//            last_addr_i             - inclusive last window address
//            mem_req_o/addr_o        - read request and address
//            mem_ack_i/data_i        - read acknowledge with same-cycle data
//            busy_o, done_o          - scan in progress, completion pulse
//            res_valid_o             - count/extreme hold a final result
//            count_o, extreme_o      - peak/valley count, max/min sample
//            sign_o                  - res_valid & extreme sign bit
// Revision : 1.0 - initial release
// ============================================================================
module peak_scan_unit #(
  parameter int DW = 9,
  parameter int AW = 5
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic          mode_i,
  input  logic [AW-1:0] last_addr_i,
  output logic          mem_req_o,
  output logic [AW-1:0] mem_addr_o,
  input  logic          mem_ack_i,
  input  logic [DW-1:0] mem_data_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          res_valid_o,
  output logic [AW-1:0] count_o,
  output logic [DW-1:0] extreme_o,
  output logic          sign_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH0 = 2'd1,
    S_FETCH  = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          mode_q, mode_d;
  logic [AW-1:0] last_q, last_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] count_q, count_d;
  logic [DW-1:0] extreme_q, extreme_d;
  logic [DW-1:0] prev_q, prev_d;
  logic          flag_q, flag_d;
  logic          done_q, done_d;
  logic          res_valid_q, res_valid_d;

  // Signed comparisons at full sample width, so no wrap is possible.
  logic rise_w, fall_w, beyond_w;
  logic closes_w, opens_w;

  assign rise_w = $signed(mem_data_i) > $signed(prev_q);
  assign fall_w = $signed(mem_data_i) < $signed(prev_q);
  // "Beyond" means a new maximum in peak mode or a new minimum in valley mode.
  assign beyond_w = mode_q ? ($signed(mem_data_i) < $signed(extreme_q))
                           : ($signed(mem_data_i) > $signed(extreme_q));
  // A peak closes on a fall after a rise; a valley closes on a rise after a fall.
  assign closes_w = mode_q ? rise_w : fall_w;
  assign opens_w  = mode_q ? fall_w : rise_w;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    last_d      = last_q;
    addr_d      = addr_q;
    count_d     = count_q;
    extreme_d   = extreme_q;
    prev_d      = prev_q;
    flag_d      = flag_q;
    done_d      = 1'b0;
    res_valid_d = res_valid_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mode_d      = mode_i;
          last_d      = last_addr_i;
          count_d     = '0;
          flag_d      = 1'b0;
          res_valid_d = 1'b0;
          addr_d      = '0;
          state_d     = S_FETCH0;
        end
      end
      S_FETCH0: begin
        if (mem_ack_i) begin
          prev_d    = mem_data_i;
          extreme_d = mem_data_i;
          if (last_q == '0) begin
            // Single-sample window completes immediately.
            done_d      = 1'b1;
            res_valid_d = 1'b1;
            state_d     = S_HOLD;
          end else begin
            addr_d  = AW'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (mem_ack_i) begin
          if (closes_w && flag_q) count_d = count_q + AW'(1);
          if (closes_w) flag_d = 1'b0;
          else if (opens_w) flag_d = 1'b1;
          if (beyond_w) extreme_d = mem_data_i;
          prev_d = mem_data_i;
          if (addr_q == last_q) begin
            done_d      = 1'b1;
            res_valid_d = 1'b1;
            state_d     = S_HOLD;
          end else begin
            addr_d = addr_q + AW'(1);
          end
        end
      end
      S_HOLD: begin
        // A fresh scan requires start to be seen low first.
        if (!start_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      mode_q      <= 1'b0;
      last_q      <= '0;
      addr_q      <= '0;
      count_q     <= '0;
      extreme_q   <= '0;
      prev_q      <= '0;
      flag_q      <= 1'b0;
      done_q      <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      extreme_q   <= extreme_d;
      prev_q      <= prev_d;
      flag_q      <= flag_d;
      done_q      <= done_d;
      res_valid_q <= res_valid_d;
    end
  end

  // Request decodes straight from state, so an async reset drops it at once.
  assign mem_req_o   = (state_q == S_FETCH0) || (state_q == S_FETCH);
  assign busy_o      = mem_req_o;
  assign mem_addr_o  = addr_q;
  assign done_o      = done_q;
  assign res_valid_o = res_valid_q;
  assign count_o     = count_q;
  assign extreme_o   = extreme_q;
  assign sign_o      = res_valid_q & extreme_q[DW-1];

endmodule
`default_nettype wire

// File: tb/tb_peak_scan_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_peak_scan_unit
// Purpose  : Directed bench for peak_scan_unit. A memory responder model
//            serves reads with configurable wait states and spurious acks;
//            expected scan results are queued at start and checked by a
//            monitor whenever done is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_peak_scan_unit;
  localparam int DW = 9;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [AW-1:0] last_addr = '0;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_data = '0;
  logic          mem_req_o;
  logic [AW-1:0] mem_addr_o;
  logic          busy_o, done_o, res_valid_o, sign_o;
  logic [AW-1:0] count_o;
  logic [DW-1:0] extreme_o;

  peak_scan_unit #(.DW(DW), .AW(AW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .mode_i(mode),
    .last_addr_i(last_addr), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_ack_i(mem_ack), .mem_data_i(mem_data), .busy_o(busy_o),
    .done_o(done_o), .res_valid_o(res_valid_o), .count_o(count_o),
    .extreme_o(extreme_o), .sign_o(sign_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wait_states = 0;
  bit spurious = 1'b0;
  int accepted = 0;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  typedef struct {
    logic [AW-1:0] cnt;
    logic [DW-1:0] ext;
    logic          sgn;
    int            exp_cyc;
    int            exp_acc;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Edge counter: value k labels the k-th rising edge.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory responder: drives ack/data on the falling edge so they are settled
  // for the next rising edge; holds off ack for wait_states cycles per read.
  initial begin
    int wc;
    logic [AW-1:0] held;
    wc = 0;
    held = '0;
    forever begin
      @(negedge clk);
      if (mem_req_o) begin
        if (wc > 0) check("addr_stable", 32'(mem_addr_o), 32'(held));
        if (wc >= wait_states) begin
          mem_ack  = 1'b1;
          mem_data = mem[mem_addr_o];
          accepted++;
          wc = 0;
        end else begin
          if (wc == 0) held = mem_addr_o;
          mem_ack  = 1'b0;
          mem_data = DW'($urandom);
          wc++;
        end
      end else begin
        wc = 0;
        mem_ack  = spurious && ($urandom_range(0, 1) == 1);
        mem_data = DW'($urandom);
      end
    end
  end

  // Monitor: pops one expectation per done pulse.
  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (done_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no completion");
      end else begin
        e = sb.pop_front();
        check("count", 32'(count_o), 32'(e.cnt));
        check("extreme", 32'(extreme_o), 32'(e.ext));
        check("sign", 32'(sign_o), 32'(e.sgn));
        check("res_valid", 32'(res_valid_o), 32'd1);
        check("busy_at_done", 32'(busy_o), 32'd0);
        if (e.exp_cyc >= 0) check("done_cycle", 32'(cyc), 32'(e.exp_cyc));
        check("accepted_acks", 32'(accepted), 32'(e.exp_acc));
        @(posedge clk);
        #1;
        check("done_pulse_width", 32'(done_o), 32'd0);
        check("res_valid_held", 32'(res_valid_o), 32'd1);
      end
    end
  end

  // Starts a scan (start left high), queues the expected result and waits.
  task automatic run_scan(input logic m, input int last, input int ws, input bit sp,
                          input int ecnt, input logic [DW-1:0] eext);
    exp_t e;
    int   t;
    wait_states = ws;
    spurious    = sp;
    @(posedge clk);
    #1;
    mode      = m;
    last_addr = AW'(last);
    accepted  = 0;
    start     = 1'b1;
    t         = cyc + 1;  // edge that samples start
    e.cnt     = AW'(ecnt);
    e.ext     = eext;
    e.sgn     = eext[DW-1];
    // Zero-wait: done is visible right after edge t+last+1.
    e.exp_cyc = (ws == 0) ? t + last + 1 : -1;
    e.exp_acc = last + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check("count_cleared", 32'(count_o), 32'd0);
    check("res_valid_cleared", 32'(res_valid_o), 32'd0);
    check("busy_started", 32'(busy_o), 32'd1);
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scan_timeout: got no done expected done within 300 cycles");
      sb.delete();
    end
  endtask

  task automatic release_start();
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic load_peak_data();
    mem[0] = 9'd1; mem[1] = 9'd3; mem[2] = 9'd2;
    mem[3] = 9'd5; mem[4] = 9'd4; mem[5] = 9'd4;
  endtask

  initial begin
    bit req_seen;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", 32'(mem_req_o), 32'd0);
    check("rst_addr", 32'(mem_addr_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_res_valid", 32'(res_valid_o), 32'd0);
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_extreme", 32'(extreme_o), 32'd0);
    check("rst_sign", 32'(sign_o), 32'd0);
    rst_n = 1'b1;

    // Peak mode, zero-wait
    load_peak_data();
    run_scan(1'b0, 5, 0, 1'b0, 2, 9'd5);
    release_start();

    // Valley mode, same data
    run_scan(1'b1, 5, 0, 1'b0, 1, 9'd1);
    release_start();

    // Signed samples: -10, -30, -5, -20
    mem[0] = 9'h1F6; mem[1] = 9'h1E2; mem[2] = 9'h1FB; mem[3] = 9'h1EC;
    run_scan(1'b0, 3, 0, 1'b0, 1, 9'h1FB);
    release_start();

    // Wait states plus spurious acks while idle
    load_peak_data();
    run_scan(1'b0, 5, 3, 1'b1, 2, 9'd5);

    // start held high after done: no rescan
    req_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_req_o) req_seen = 1'b1;
    end
    check("hold_no_req", 32'(req_seen), 32'd0);
    check("hold_res_valid", 32'(res_valid_o), 32'd1);
    check("hold_count", 32'(count_o), 32'd2);
    release_start();

    // Toggled start rescans (count cleared checked inside run_scan)
    run_scan(1'b0, 5, 0, 1'b0, 2, 9'd5);
    release_start();

    // Single-sample window
    mem[0] = 9'h100;
    run_scan(1'b0, 0, 0, 1'b0, 0, 9'h100);
    release_start();

    // Reset mid-FETCH aborts the scan immediately
    load_peak_data();
    wait_states = 2;
    spurious    = 1'b0;
    @(posedge clk);
    #1;
    mode = 1'b0;
    last_addr = AW'(5);
    start = 1'b1;
    repeat (5) @(posedge clk);
    #3;
    check("pre_abort_req", 32'(mem_req_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_req", 32'(mem_req_o), 32'd0);
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_addr", 32'(mem_addr_o), 32'd0);
    check("abort_count", 32'(count_o), 32'd0);
    check("abort_extreme", 32'(extreme_o), 32'd0);
    check("abort_res_valid", 32'(res_valid_o), 32'd0);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_abort_idle_busy", 32'(busy_o), 32'd0);
    check("post_abort_idle_req", 32'(mem_req_o), 32'd0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000ns");
    $fatal(1);
  end

endmodule
`default_nettype wire
